// File: rtl/aes_sub_bytes.sv
// rtl/aes_sub_bytes.sv - forward AES SubBytes engine, LANES S-box lookups per clock
module aes_sub_bytes #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [127:0] state_in,
  output logic         ready_out,
  output logic         valid_out,
  output logic [127:0] state_out,
  input  logic         ready_in
);

  // Only divisors of 16 that are powers of two give a whole number of rotations.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int            STEPS = 16 / LANES;
  localparam int            CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

  // Forward S-box, element 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [127:0]        work_q, work_d;
  logic [127:0]        out_q, out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [8*LANES-1:0]  sub;
  logic [127:0]        rot;

  // Substitute the top LANES bytes and rotate them to the bottom of the word.
  always_comb begin
    sub = '0;
    for (int i = 0; i < LANES; i++) begin
      sub[8*(LANES-1-i) +: 8] = sbox(work_q[127-8*i -: 8]);
    end
    rot = (work_q << (8 * LANES)) | 128'(sub);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_in) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  if (ready_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: load on accept, rotate while running, capture the result.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          work_d = state_in;
          cnt_d  = '0;
        end
      end
      S_RUN: begin
        work_d = rot;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) out_d = rot;
      end
      default: ;
    endcase
  end

  // Datapath registers; a reset mid-run discards the partial result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_q <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  // Handshake outputs decode the registered state; the result comes straight from a flop.
  always_comb begin
    ready_out = (state_q == S_IDLE);
    valid_out = (state_q == S_DONE);
    state_out = out_q;
  end

endmodule

// File: tb/tb_aes_sub_bytes.sv
// tb/tb_aes_sub_bytes.sv - directed self-checking bench for aes_sub_bytes
module tb_aes_sub_bytes;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] state_in = '0;
  logic         v1 = 1'b0, v4 = 1'b0, v16 = 1'b0;
  logic         r1 = 1'b1, r4 = 1'b1, r16 = 1'b1;
  logic         ro1, ro4, ro16, vo1, vo4, vo16;
  logic [127:0] so1, so4, so16;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  always #5 clk = ~clk;

  aes_sub_bytes #(.LANES(1)) u_l1 (
    .clk(clk), .reset(reset), .valid_in(v1), .state_in(state_in),
    .ready_out(ro1), .valid_out(vo1), .state_out(so1), .ready_in(r1));
  aes_sub_bytes #(.LANES(4)) u_l4 (
    .clk(clk), .reset(reset), .valid_in(v4), .state_in(state_in),
    .ready_out(ro4), .valid_out(vo4), .state_out(so4), .ready_in(r4));
  aes_sub_bytes #(.LANES(16)) u_l16 (
    .clk(clk), .reset(reset), .valid_in(v16), .state_in(state_in),
    .ready_out(ro16), .valid_out(vo16), .state_out(so16), .ready_in(r16));

  // Algebraic S-box model: GF(2^8) inverse plus affine map.
  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return (a == 8'h00) ? 8'h00 : r;
  endfunction

  function automatic logic [7:0] fwd(input logic [7:0] b);
    logic [7:0] x;
    x = ginv(b);
    return x ^ rol(x, 1) ^ rol(x, 2) ^ rol(x, 3) ^ rol(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv(input logic [7:0] y);
    return ginv(rol(y, 1) ^ rol(y, 3) ^ rol(y, 6) ^ 8'h05);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic vo_of(input int w);
    return (w == 1) ? vo1 : (w == 4) ? vo4 : vo16;
  endfunction

  function automatic logic [127:0] so_of(input int w);
    return (w == 1) ? so1 : (w == 4) ? so4 : so16;
  endfunction

  task automatic set_valid(input int w, input logic v);
    if (w == 1) v1 = v;
    else if (w == 4) v4 = v;
    else v16 = v;
  endtask

  // Accept one state, wait (bounded) for the result, consume it with ready_in high.
  task automatic run(input int w, input logic [127:0] din, output logic [127:0] dout, output int lat);
    state_in = din;
    set_valid(w, 1'b1);
    tick();
    set_valid(w, 1'b0);
    lat = 0;
    while (!vo_of(w) && lat < 64) begin
      tick();
      lat++;
    end
    dout = so_of(w);
    tick();
  endtask

  initial begin
    logic [127:0] dout, din, exp, recon, saved;
    int lat;

    // Reset held with random inputs driven.
    for (int i = 0; i < 4; i++) begin
      state_in = {$urandom, $urandom, $urandom, $urandom};
      v1 = 1'($urandom); v4 = 1'($urandom); v16 = 1'($urandom);
      r1 = 1'($urandom); r4 = 1'($urandom); r16 = 1'($urandom);
      tick();
    end
    chk("rst_ready_l1", 128'(ro1), 128'd1);
    chk("rst_valid_l1", 128'(vo1), 128'd0);
    chk("rst_out_l1", so1, 128'd0);
    chk("rst_ready_l16", 128'(ro16), 128'd1);
    chk("rst_out_l4", so4, 128'd0);
    v1 = 0; v4 = 0; v16 = 0; r1 = 1; r4 = 1; r16 = 1;
    reset = 1'b1;
    tick();
    chk("idle_after_rst", {125'd0, ro1, ro4, ro16}, 128'd7);

    // FIPS-197 Appendix B vector at LANES=1.
    run(1, APPB_IN, dout, lat);
    chk("appb_l1", dout, APPB_OUT);
    chk("appb_l1_lat", 128'(lat), 128'd16);
    chk("appb_l1_back_idle", {126'd0, ro1, vo1}, 128'd2);

    // Table sweep at LANES=4, with inverse round trip.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) din[127-8*j -: 8] = 8'(k * 16 + j);
      for (int j = 0; j < 16; j++) exp[127-8*j -: 8] = fwd(din[127-8*j -: 8]);
      run(4, din, dout, lat);
      chk($sformatf("sweep_%0d", k), dout, exp);
      for (int j = 0; j < 16; j++) recon[127-8*j -: 8] = inv(dout[127-8*j -: 8]);
      chk($sformatf("inverse_%0d", k), recon, din);
      if (k == 0)  chk("row_00", dout, 128'h637c777bf26b6fc53001672bfed7ab76);
      if (k == 15) chk("row_f0", dout, 128'h8ca1890dbfe6426841992d0fb054bb16);
    end

    // Back-pressure: DONE held 20 cycles, new valid_in ignored.
    r1 = 1'b0;
    state_in = APPB_IN;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    lat = 0;
    while (!vo1 && lat < 64) begin
      tick();
      lat++;
    end
    saved = so1;
    chk("bp_result", saved, APPB_OUT);
    for (int i = 0; i < 20; i++) begin
      state_in = {$urandom, $urandom, $urandom, $urandom};
      v1 = 1'b1;
      tick();
      chk($sformatf("bp_hold_%0d", i), {so1, vo1, ro1} , {saved, 1'b1, 1'b0});
    end
    r1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("bp_release", {126'd0, ro1, vo1}, 128'd2);
    chk("bp_out_kept", so1, APPB_OUT);

    // Reset asserted mid-run at counter 7.
    state_in = {16{8'h53}};
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    repeat (7) tick();
    #2 reset = 1'b0;
    #1;
    chk("midrun_rst_out", so1, 128'd0);
    chk("midrun_rst_hs", {126'd0, ro1, vo1}, 128'd2);
    chk("midrun_rst_out_l4", so4, 128'd0);
    tick();
    #2 reset = 1'b1;
    tick();
    run(1, 128'd0, dout, lat);
    chk("zeros_l1", dout, {16{8'h63}});
    run(16, {16{8'h53}}, dout, lat);
    chk("all53_l16", dout, {16{8'hed}});

    // Appendix B at wider lane counts.
    run(4, APPB_IN, dout, lat);
    chk("appb_l4", dout, APPB_OUT);
    chk("appb_l4_lat", 128'(lat), 128'd4);
    run(16, APPB_IN, dout, lat);
    chk("appb_l16", dout, APPB_OUT);
    chk("appb_l16_lat", 128'(lat), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
